// File: rtl/ga_arith_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : ga_arith_pkg
//  Description : Shared arithmetic defaults and FSM encoding for the
//                GeneticAlgorithm datapath arithmetic blocks.
//  Revision    : 1.0 - initial release
// ============================================================================
package ga_arith_pkg;

    localparam int DATA_W  = 48;
    localparam int SLICE_W = 16;

    // Sequential arithmetic unit control states
    typedef enum logic [0:0] {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_e;

endpackage : ga_arith_pkg
`default_nettype wire

// File: rtl/sub_slice.sv
`default_nettype none
// ============================================================================
//  Module      : sub_slice
//  Description : Combinational W-bit borrow slice: {B_out, D} = A - B - B_in.
//                Implemented as A + ~B + !B_in; borrow is the inverted carry.
//  Revision    : 1.0 - initial release
// ============================================================================
module sub_slice
    import ga_arith_pkg::*;
#(
    parameter int W = SLICE_W
) (
    input  logic [W-1:0] A,
    input  logic [W-1:0] B,
    input  logic         B_in,
    output logic [W-1:0] D,
    output logic         B_out
);

    logic [W:0] w_sum;

    // Add the one's complement of B; carry-in of 1 means no incoming borrow
    always_comb begin
        w_sum = {1'b0, A} + {1'b0, ~B} + {{W{1'b0}}, ~B_in};
        D     = w_sum[W-1:0];
        B_out = ~w_sum[W];
    end

endmodule : sub_slice
`default_nettype wire

// File: rtl/sub_seq48.sv
`default_nettype none
// ============================================================================
//  Module      : sub_seq48
//  Description : Multi-cycle DATA_W-bit subtractor. One SLICE_W borrow slice
//                is reused LSB-first, one slice per cycle, under a 2-state FSM.
//                Pulse handshake: sub_en starts, diff_vail flags the result.
//  Revision    : 1.0 - initial release
// ============================================================================
module sub_seq48
    import ga_arith_pkg::*;
#(
    parameter int DATA_W  = ga_arith_pkg::DATA_W,
    parameter int SLICE_W = ga_arith_pkg::SLICE_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [DATA_W-1:0] operand1,
    input  logic [DATA_W-1:0] operand2,
    input  logic              sub_en,
    output logic [DATA_W-1:0] diff,
    output logic              diff_vail,
    output logic              borrow_out,
    output logic              overflow,
    output logic              busy
);

    localparam int NUM_SLICES = DATA_W / SLICE_W;
    localparam int IDX_W      = (NUM_SLICES > 1) ? $clog2(NUM_SLICES) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_SLICES - 1);

    state_e              state_q;
    logic [IDX_W-1:0]    idx_q;
    logic                borrow_q;
    logic [DATA_W-1:0]   op1_q;
    logic [DATA_W-1:0]   op2_q;
    logic [DATA_W-1:0]   part_q;
    logic [DATA_W-1:0]   diff_q;
    logic                vail_q;
    logic                bout_q;
    logic                ovf_q;

    logic [SLICE_W-1:0]  w_sa;
    logic [SLICE_W-1:0]  w_sb;
    logic [SLICE_W-1:0]  w_sd;
    logic                w_sbout;
    logic [DATA_W-1:0]   part_d;

    // Select the operand slices addressed by the current index
    always_comb begin
        w_sa = op1_q[idx_q*SLICE_W +: SLICE_W];
        w_sb = op2_q[idx_q*SLICE_W +: SLICE_W];
    end

    sub_slice #(
        .W (SLICE_W)
    ) u_slice (
        .A     (w_sa),
        .B     (w_sb),
        .B_in  (borrow_q),
        .D     (w_sd),
        .B_out (w_sbout)
    );

    // Partial result with the current slice merged in
    always_comb begin
        part_d = part_q;
        part_d[idx_q*SLICE_W +: SLICE_W] = w_sd;
    end

    // Control FSM, operand capture and registered result outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            idx_q    <= '0;
            borrow_q <= 1'b0;
            op1_q    <= '0;
            op2_q    <= '0;
            part_q   <= '0;
            diff_q   <= '0;
            vail_q   <= 1'b0;
            bout_q   <= 1'b0;
            ovf_q    <= 1'b0;
        end else begin
            vail_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (sub_en) begin
                        op1_q    <= operand1;
                        op2_q    <= operand2;
                        idx_q    <= '0;
                        borrow_q <= 1'b0;
                        state_q  <= RUN;
                    end
                end
                RUN: begin
                    part_q   <= part_d;
                    borrow_q <= w_sbout;
                    idx_q    <= idx_q + IDX_W'(1);
                    if (idx_q == LAST_IDX) begin
                        diff_q  <= part_d;
                        bout_q  <= w_sbout;
                        // Signed overflow: operands of opposite sign and the
                        // result sign disagrees with the minuend
                        ovf_q   <= (op1_q[DATA_W-1] != op2_q[DATA_W-1]) &&
                                   (w_sd[SLICE_W-1] != op1_q[DATA_W-1]);
                        vail_q  <= 1'b1;
                        state_q <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign diff       = diff_q;
    assign diff_vail  = vail_q;
    assign borrow_out = bout_q;
    assign overflow   = ovf_q;
    assign busy       = (state_q == RUN);

endmodule : sub_seq48
`default_nettype wire

// File: tb/tb_sub_seq48.sv
`default_nettype none
// ============================================================================
//  Module      : tb_sub_seq48
//  Description : Self-checking bench for sub_seq48: vector table plus
//                hand-written busy/back-to-back and mid-run reset sequences.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_sub_seq48;

    logic        clk = 1'b0;
    logic        rst;
    logic [47:0] operand1;
    logic [47:0] operand2;
    logic        sub_en;
    logic [47:0] diff;
    logic        diff_vail;
    logic        borrow_out;
    logic        overflow;
    logic        busy;

    int total = 0;
    int bad   = 0;

    typedef struct {
        logic [47:0] op1;
        logic [47:0] op2;
        logic [47:0] exp_diff;
        logic        exp_b;
        logic        exp_ov;
    } vec_t;

    vec_t vecs[8];

    sub_seq48 dut (
        .clk        (clk),
        .rst        (rst),
        .operand1   (operand1),
        .operand2   (operand2),
        .sub_en     (sub_en),
        .diff       (diff),
        .diff_vail  (diff_vail),
        .borrow_out (borrow_out),
        .overflow   (overflow),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input logic [47:0] act, input logic [47:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    // Advance to the next cycle; outputs sampled 1 time unit after the edge
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // One operation from a table entry; cycle 0 is the sub_en cycle
    task automatic run_vec(input vec_t v);
        sub_en   = 1'b1;
        operand1 = v.op1;
        operand2 = v.op2;
        chk("vail_c0", {47'd0, diff_vail}, 48'd0);
        step();
        sub_en   = 1'b0;
        operand1 = {$urandom(), $urandom()};
        operand2 = {$urandom(), $urandom()};
        for (int c = 1; c <= 6; c++) begin
            chk($sformatf("vail_c%0d", c), {47'd0, diff_vail}, {47'd0, (c == 4)});
            if (c == 1) chk("busy_c1", {47'd0, busy}, 48'd1);
            if (c == 4) begin
                chk("diff", diff, v.exp_diff);
                chk("borrow", {47'd0, borrow_out}, {47'd0, v.exp_b});
                chk("ovf", {47'd0, overflow}, {47'd0, v.exp_ov});
                chk("busy_c4", {47'd0, busy}, 48'd0);
            end
            if (c == 6) chk("diff_hold", diff, v.exp_diff);
            step();
        end
    endtask

    initial begin
        vecs[0] = '{48'h000000000005, 48'h000000000003, 48'h000000000002, 1'b0, 1'b0};
        vecs[1] = '{48'h000000010000, 48'h000000000001, 48'h00000000FFFF, 1'b0, 1'b0};
        vecs[2] = '{48'h000000000000, 48'h000000000001, 48'hFFFFFFFFFFFF, 1'b1, 1'b0};
        vecs[3] = '{48'h800000000000, 48'h000000000001, 48'h7FFFFFFFFFFF, 1'b0, 1'b1};
        vecs[4] = '{48'h123456789ABC, 48'h111111111111, 48'h0123456789AB, 1'b0, 1'b0};
        vecs[5] = '{48'h7FFFFFFFFFFF, 48'hFFFFFFFFFFFF, 48'h800000000000, 1'b1, 1'b1};
        vecs[6] = '{48'hFFFFFFFFFFFF, 48'hFFFFFFFFFFFF, 48'h000000000000, 1'b0, 1'b0};
        vecs[7] = '{48'h000100000000, 48'h000000000001, 48'h0000FFFFFFFF, 1'b0, 1'b0};

        rst      = 1'b1;
        sub_en   = 1'b1;
        operand1 = 48'h5;
        operand2 = 48'h3;
        step();
        step();
        // Reset state (sub_en held high: reset must win)
        chk("rst_diff", diff, 48'd0);
        chk("rst_vail", {47'd0, diff_vail}, 48'd0);
        chk("rst_borrow", {47'd0, borrow_out}, 48'd0);
        chk("rst_ovf", {47'd0, overflow}, 48'd0);
        chk("rst_busy", {47'd0, busy}, 48'd0);
        rst    = 1'b0;
        sub_en = 1'b0;
        step();

        for (int i = 0; i < 8; i++) run_vec(vecs[i]);

        // Busy rejection followed by a back-to-back start on the valid cycle
        for (int c = 0; c <= 10; c++) begin
            sub_en   = 1'b0;
            operand1 = 48'hABCDEF;
            operand2 = 48'h123;
            if (c == 0)           begin sub_en = 1'b1; operand1 = 48'h10; operand2 = 48'h01; end
            if (c == 2 || c == 3) begin sub_en = 1'b1; operand1 = 48'h20; operand2 = 48'h02; end
            if (c == 4)           begin sub_en = 1'b1; operand1 = 48'h30; operand2 = 48'h03; end
            chk($sformatf("b2b_vail_c%0d", c), {47'd0, diff_vail}, {47'd0, (c == 4 || c == 8)});
            if (c == 2 || c == 3) chk($sformatf("b2b_busy_c%0d", c), {47'd0, busy}, 48'd1);
            if (c == 4) begin
                chk("b2b_diff1", diff, 48'h0F);
                chk("b2b_busy_c4", {47'd0, busy}, 48'd0);
            end
            if (c == 8) chk("b2b_diff2", diff, 48'h2D);
            step();
        end

        // Reset mid-operation (sub_en also high at the reset edge), then recovery
        for (int c = 0; c <= 14; c++) begin
            sub_en   = 1'b0;
            rst      = 1'b0;
            operand1 = 48'h777;
            operand2 = 48'h111;
            if (c == 0) begin sub_en = 1'b1; operand1 = 48'hFFFF; operand2 = 48'h1; end
            if (c == 2) begin rst = 1'b1; sub_en = 1'b1; operand1 = 48'h9; operand2 = 48'h4; end
            if (c == 8) begin sub_en = 1'b1; operand1 = 48'h9; operand2 = 48'h4; end
            chk($sformatf("rr_vail_c%0d", c), {47'd0, diff_vail}, {47'd0, (c == 12)});
            if (c >= 3 && c <= 8) begin
                chk($sformatf("rr_busy_c%0d", c), {47'd0, busy}, 48'd0);
                chk($sformatf("rr_diff_c%0d", c), diff, 48'd0);
            end
            if (c == 12) begin
                chk("rr_diff", diff, 48'h5);
                chk("rr_borrow", {47'd0, borrow_out}, 48'd0);
            end
            step();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule : tb_sub_seq48
`default_nettype wire

// File: doc/sub_seq48.md
Name: sub_seq48

Overview:
- Multi-cycle 48-bit subtractor: diff = operand1 - operand2. The GeneticAlgorithm datapath uses it wherever fitness/bound comparisons need a difference instead of a sum.
- A single SLICE_W-bit borrow slice is reused once per slice, LSB slice first, under a small FSM. Area is one slice instead of three.
- Same en/vail pulse handshake as the datapath adders: a one-cycle start pulse in, a one-cycle valid pulse out.

Parameters:
- DATA_W, 48, operand/result width; must be an integer multiple of SLICE_W.
- SLICE_W, 16, width of the subtract slice processed per cycle.
- NUM_SLICES, DATA_W/SLICE_W (=3), derived localparam; not overridable.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  synchronous, active-high reset.
- operand1  input  DATA_W  minuend; sampled only on an accepted sub_en.
- operand2  input  DATA_W  subtrahend; sampled only on an accepted sub_en.
- sub_en  input  1  start pulse; accepted only when busy=0.
- diff  output  DATA_W  result; registered, held until the next completion.
- diff_vail  output  1  one-cycle pulse: diff, borrow_out and overflow are valid.
- borrow_out  output  1  unsigned borrow (1 when operand1 < operand2).
- overflow  output  1  two's-complement signed overflow of the subtraction.
- busy  output  1  high while an operation is in flight.

Behaviour:
- Reset (rst=1 at a clock edge):
  - state=IDLE, slice index=0, internal borrow=0.
  - diff=0, diff_vail=0, borrow_out=0, overflow=0, busy=0.
  - rst has priority over sub_en at the same edge.
- FSM states: IDLE, RUN.
- IDLE:
  - busy=0.
  - On sub_en=1: capture operand1/operand2 into op buffers, idx<=0, borrow<=0, go to RUN.
- RUN:
  - busy=1.
  - Each cycle, the slice computes {b_out, d} = opA[idx] - opB[idx] - borrow.
  - Register d into the partial-result buffer at slice idx; borrow<=b_out; idx<=idx+1.
  - On the last slice (idx=NUM_SLICES-1), at the same edge:
    - diff <= full buffer including this slice.
    - borrow_out <= b_out.
    - overflow <= (op1 MSB != op2 MSB) && (diff MSB != op1 MSB).
    - diff_vail <= 1; state <= IDLE.
- Latency: with sub_en accepted at the edge ending cycle n, diff_vail is high in cycle n+1+NUM_SLICES (n+4 at default).
- diff_vail is 0 in every other cycle.
- Throughput: one operation per NUM_SLICES+1 cycles. A new sub_en in the cycle where diff_vail=1 is accepted, since the FSM is already IDLE.
- sub_en while busy=1 is ignored: no queueing, operands not recaptured, no extra diff_vail.
- Operand inputs may change freely after acceptance; the result depends only on the captured values.
- Wrap-around: the result is modulo 2^DATA_W. A negative difference gives the two's-complement pattern with borrow_out=1.
- diff, borrow_out and overflow hold their values between completions. They are overwritten only at a completion or by rst.
- Reset mid-RUN aborts the operation: no diff_vail, outputs go to their reset values, FSM returns to IDLE.

Decomposition:
- Shared package (ga_arith_pkg): DATA_W/SLICE_W defaults and the state encoding (IDLE=1'b0, RUN=1'b1).
- One natural sub-module: sub_slice, purely combinational.
  - Inputs: A, B (SLICE_W), B_in.
  - Outputs: D (SLICE_W), B_out.
  - Function: {B_out, D} = A - B - B_in, computed as A + ~B + !B_in, with B_out the inverted carry.
- Slice select and partial-result writes are indexed by idx; no per-slice instances.

Test Plan:
- Basic subtract: op1=0x000000000005, op2=0x000000000003, one-cycle sub_en at cycle 0 -> diff_vail only in cycle 4; diff=0x000000000002, borrow_out=0, overflow=0.
- Borrow across a slice boundary: op1=0x000000010000, op2=0x000000000001 -> diff=0x00000000FFFF, borrow_out=0, overflow=0.
- Underflow wrap: op1=0x000000000000, op2=0x000000000001 -> diff=0xFFFFFFFFFFFF, borrow_out=1, overflow=0.
- Signed overflow: op1=0x800000000000, op2=0x000000000001 -> diff=0x7FFFFFFFFFFF, borrow_out=0, overflow=1.
- Busy rejection and back-to-back:
  - Start 0x10-0x01.
  - Pulse sub_en with 0x20-0x02 in cycles 2 and 3 -> exactly one diff_vail (cycle 4), diff=0x0F.
  - Pulse sub_en in cycle 4 with 0x30-0x03 -> diff_vail in cycle 8, diff=0x2D.
- Reset mid-operation: start 0xFFFF-0x1, assert rst in cycle 2 -> busy=0 and diff=0 from cycle 3, no diff_vail. A subsequent 0x9-0x4 completes normally with diff=0x5.
